// File: rtl/vin_rcservo.sv
// vin_rcservo: RC-servo pulse decoder.
// Measures PWM high time, reports clamped offset from center, period and validity.
module vin_rcservo #(
    parameter int unsigned SERVO_CENTER  = 72000,
    parameter int unsigned SERVO_MINMAX  = 72000,
    parameter int unsigned SERVO_TIMEOUT = 960000,
    parameter int unsigned FILTER_LEN    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PWM,
    output logic signed [31:0] rcValue,
    output logic        [31:0] rcPeriod,
    output logic               rcValid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [31:0]        C_TIMEOUT = 32'(SERVO_TIMEOUT);
    localparam logic [3:0]         C_FLEN    = 4'(FILTER_LEN);
    localparam logic signed [32:0] C_CENTER  = 33'(SERVO_CENTER);
    localparam logic signed [32:0] C_MAX     = 33'(SERVO_MINMAX);
    localparam logic signed [32:0] C_MIN     = -C_MAX;

    logic        r_sync1;
    logic        r_sync2;
    logic [3:0]  r_fcnt;
    logic        r_pwm_f;
    logic        r_prev;
    logic [1:0]  r_prime;
    logic [3:0]  r_lowcnt;
    logic        r_armed;
    logic [1:0]  r_state;
    logic [31:0] r_width;
    logic [31:0] r_period;
    logic signed [31:0] r_rc_value;
    logic [31:0] r_rc_period;
    logic        r_rc_valid;

    logic               w_rise;
    logic               w_fall;
    logic signed [32:0] w_diff;
    logic signed [31:0] w_value;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v >= C_TIMEOUT) ? v : v + 32'd1;
    endfunction

    // Synchronise the pin and accept a new level only after FILTER_LEN equal samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_fcnt  <= 4'd0;
            r_pwm_f <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= PWM;
            r_sync2 <= r_sync1;
            r_prev  <= r_pwm_f;
            if (r_sync2 != r_pwm_f) begin
                if (r_fcnt + 4'd1 >= C_FLEN) begin
                    r_pwm_f <= r_sync2;
                    r_fcnt  <= 4'd0;
                end else begin
                    r_fcnt <= r_fcnt + 4'd1;
                end
            end else begin
                r_fcnt <= 4'd0;
            end
        end
    end

    // Arm only after a genuine filtered low is seen, so a pulse high at reset is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prime  <= 2'b00;
            r_lowcnt <= 4'd0;
            r_armed  <= 1'b0;
        end else begin
            r_prime <= {r_prime[0], 1'b1};
            if (r_prime[1] && !r_sync2) begin
                if (r_lowcnt + 4'd1 >= C_FLEN) begin
                    r_armed <= 1'b1;
                end else begin
                    r_lowcnt <= r_lowcnt + 4'd1;
                end
            end else begin
                r_lowcnt <= 4'd0;
            end
        end
    end

    assign w_rise = r_pwm_f & ~r_prev;
    assign w_fall = ~r_pwm_f & r_prev;

    // Signed offset of the measured width from center, clamped to +/- minmax.
    always_comb begin
        w_diff  = $signed({1'b0, r_width}) - C_CENTER;
        w_value = w_diff[31:0];
        if (w_diff > C_MAX) begin
            w_value = C_MAX[31:0];
        end else if (w_diff < C_MIN) begin
            w_value = C_MIN[31:0];
        end
    end

    // Frame FSM: width/period measurement with timeout failsafe taking priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_width     <= 32'd0;
            r_period    <= 32'd0;
            r_rc_value  <= 32'sd0;
            r_rc_period <= 32'd0;
            r_rc_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise && r_armed) begin
                        r_state  <= S_HIGH;
                        r_width  <= 32'd1;
                        r_period <= 32'd1;
                    end
                end
                S_HIGH: begin
                    if (r_width >= C_TIMEOUT) begin
                        r_state     <= S_IDLE;
                        r_rc_value  <= 32'sd0;
                        r_rc_period <= 32'd0;
                        r_rc_valid  <= 1'b0;
                    end else begin
                        r_width  <= sat_inc(r_width);
                        r_period <= sat_inc(r_period);
                        if (w_fall) begin
                            r_state    <= S_LOW;
                            r_rc_value <= w_value;
                            r_rc_valid <= 1'b1;
                        end
                    end
                end
                S_LOW: begin
                    if (r_period >= C_TIMEOUT) begin
                        r_state     <= S_IDLE;
                        r_rc_value  <= 32'sd0;
                        r_rc_period <= 32'd0;
                        r_rc_valid  <= 1'b0;
                    end else if (w_rise) begin
                        r_rc_period <= r_period;
                        r_width     <= 32'd1;
                        r_period    <= 32'd1;
                        r_state     <= S_HIGH;
                    end else begin
                        r_period <= sat_inc(r_period);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rcValue  = r_rc_value;
    assign rcPeriod = r_rc_period;
    assign rcValid  = r_rc_valid;

endmodule

// File: tb/tb_vin_rcservo.sv
// tb_vin_rcservo: self-checking bench for the RC-servo pulse decoder.
// Scaled timing parameters keep the run short.
module tb_vin_rcservo;

    localparam int C = 150;
    localparam int M = 60;
    localparam int T = 1000;
    localparam int F = 3;
    localparam int L = 2 + F;

    logic               clk;
    logic               rst_n;
    logic               PWM;
    logic signed [31:0] rcValue;
    logic        [31:0] rcPeriod;
    logic               rcValid;

    int n_checks;
    int n_fail;

    // Reference model state
    int exp_value;
    int exp_period;
    bit exp_valid;
    bit first;
    int prev_len;

    vin_rcservo #(
        .SERVO_CENTER (C),
        .SERVO_MINMAX (M),
        .SERVO_TIMEOUT(T),
        .FILTER_LEN   (F)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .PWM     (PWM),
        .rcValue (rcValue),
        .rcPeriod(rcPeriod),
        .rcValid (rcValid)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time bound on the whole run
    initial begin
        #3ms;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int clampv(input int w);
        int d;
        d = w - C;
        if (d > M) return M;
        if (d < -M) return -M;
        return d;
    endfunction

    function automatic void model_idle();
        exp_value  = 0;
        exp_period = 0;
        exp_valid  = 1'b0;
        first      = 1'b1;
    endfunction

    // Drive one frame; optional 2-cycle dropout mid-high and spike mid-low.
    task automatic drive_frame(input int hi, input int lo, input bit gl);
        PWM = 1'b1;
        if (gl) begin
            run(hi / 2);
            PWM = 1'b0;
            run(2);
            PWM = 1'b1;
            run(hi - hi / 2 - 2);
        end else begin
            run(hi);
        end
        PWM = 1'b0;
        if (gl) begin
            run(lo / 2);
            PWM = 1'b1;
            run(2);
            PWM = 1'b0;
            run(lo - lo / 2 - 2);
        end else begin
            run(lo);
        end
        exp_value = clampv(hi);
        exp_valid = 1'b1;
        if (!first) exp_period = prev_len;
        first    = 1'b0;
        prev_len = hi + lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        PWM   = 1'b0;
        run(4);
        n_checks++;
        if (rcValue !== 0) begin
            n_fail++;
            $display("FAIL reset_value got %0d want 0", rcValue);
        end
        n_checks++;
        if (rcValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %0b want 0", rcValid);
        end
        n_checks++;
        if (rcPeriod !== 0) begin
            n_fail++;
            $display("FAIL reset_period got %0d want 0", rcPeriod);
        end
        rst_n = 1'b1;
        model_idle();
        run(20);
    endtask

    task automatic test_nominal();
        for (int i = 0; i < 3; i++) begin
            drive_frame(C, 480 - C, 1'b0);
            n_checks++;
            if (rcValue !== exp_value) begin
                n_fail++;
                $display("FAIL nominal_value[%0d] got %0d want %0d", i, rcValue, exp_value);
            end
            n_checks++;
            if (rcValid !== exp_valid) begin
                n_fail++;
                $display("FAIL nominal_valid[%0d] got %0b want %0b", i, rcValid, exp_valid);
            end
            n_checks++;
            if (rcPeriod !== exp_period) begin
                n_fail++;
                $display("FAIL nominal_period[%0d] got %0d want %0d", i, rcPeriod, exp_period);
            end
        end
    endtask

    task automatic test_widths();
        int w [6];
        w[0] = C - 36;
        w[1] = C + 48;
        w[2] = C + M;
        w[3] = C - M;
        w[4] = C + 500;
        w[5] = 10;
        for (int i = 0; i < 6; i++) begin
            drive_frame(w[i], 60, 1'b0);
            n_checks++;
            if (rcValue !== exp_value) begin
                n_fail++;
                $display("FAIL width_value[w=%0d] got %0d want %0d", w[i], rcValue, exp_value);
            end
            n_checks++;
            if (rcPeriod !== exp_period) begin
                n_fail++;
                $display("FAIL width_period[w=%0d] got %0d want %0d", w[i], rcPeriod, exp_period);
            end
        end
    endtask

    task automatic test_glitch();
        int hi;
        int lo;
        for (int i = 0; i < 5; i++) begin
            hi = int'($urandom_range(250, 30));
            lo = int'($urandom_range(300, 30));
            drive_frame(hi, lo, 1'b1);
            n_checks++;
            if (rcValue !== exp_value) begin
                n_fail++;
                $display("FAIL glitch_value[hi=%0d] got %0d want %0d", hi, rcValue, exp_value);
            end
            n_checks++;
            if (rcPeriod !== exp_period) begin
                n_fail++;
                $display("FAIL glitch_period[lo=%0d] got %0d want %0d", lo, rcPeriod, exp_period);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hi;
        int lo;
        for (int i = 0; i < 10; i++) begin
            hi = int'($urandom_range(400, 4));
            lo = int'($urandom_range(400, 20));
            drive_frame(hi, lo, 1'b0);
            n_checks++;
            if (rcValue !== exp_value) begin
                n_fail++;
                $display("FAIL b2b_value[hi=%0d] got %0d want %0d", hi, rcValue, exp_value);
            end
            n_checks++;
            if (rcValid !== exp_valid) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d] got %0b want %0b", i, rcValid, exp_valid);
            end
            n_checks++;
            if (rcPeriod !== exp_period) begin
                n_fail++;
                $display("FAIL b2b_period[%0d] got %0d want %0d", i, rcPeriod, exp_period);
            end
        end
    endtask

    task automatic test_failsafe_high();
        PWM = 1'b1;
        run(L + T);
        n_checks++;
        if (rcValid !== 1'b1) begin
            n_fail++;
            $display("FAIL fs_high_pre_valid got %0b want 1", rcValid);
        end
        run(1);
        model_idle();
        n_checks++;
        if (rcValid !== exp_valid) begin
            n_fail++;
            $display("FAIL fs_high_valid got %0b want %0b", rcValid, exp_valid);
        end
        n_checks++;
        if (rcValue !== exp_value) begin
            n_fail++;
            $display("FAIL fs_high_value got %0d want %0d", rcValue, exp_value);
        end
        n_checks++;
        if (rcPeriod !== exp_period) begin
            n_fail++;
            $display("FAIL fs_high_period got %0d want %0d", rcPeriod, exp_period);
        end
        PWM = 1'b0;
        run(50);
    endtask

    task automatic test_failsafe_low();
        PWM = 1'b1;
        run(100);
        PWM = 1'b0;
        run(L + T - 100);
        n_checks++;
        if (rcValid !== 1'b1 || rcValue !== clampv(100)) begin
            n_fail++;
            $display("FAIL fs_low_pre got valid=%0b value=%0d want valid=1 value=%0d",
                     rcValid, rcValue, clampv(100));
        end
        run(1);
        model_idle();
        n_checks++;
        if (rcValid !== exp_valid) begin
            n_fail++;
            $display("FAIL fs_low_valid got %0b want %0b", rcValid, exp_valid);
        end
        n_checks++;
        if (rcValue !== exp_value) begin
            n_fail++;
            $display("FAIL fs_low_value got %0d want %0d", rcValue, exp_value);
        end
        n_checks++;
        if (rcPeriod !== exp_period) begin
            n_fail++;
            $display("FAIL fs_low_period got %0d want %0d", rcPeriod, exp_period);
        end
    endtask

    task automatic test_reset_mid();
        drive_frame(C, 100, 1'b0);
        drive_frame(C + 20, 100, 1'b0);
        PWM = 1'b1;
        run(30);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        model_idle();
        run(80);
        PWM = 1'b0;
        run(60);
        n_checks++;
        if (rcValid !== exp_valid || rcValue !== exp_value || rcPeriod !== exp_period) begin
            n_fail++;
            $display("FAIL rstmid_ignore got v=%0b val=%0d per=%0d want v=0 val=0 per=0",
                     rcValid, rcValue, rcPeriod);
        end
        drive_frame(120, 100, 1'b0);
        n_checks++;
        if (rcValue !== exp_value) begin
            n_fail++;
            $display("FAIL rstmid_value got %0d want %0d", rcValue, exp_value);
        end
        n_checks++;
        if (rcValid !== exp_valid) begin
            n_fail++;
            $display("FAIL rstmid_valid got %0b want %0b", rcValid, exp_valid);
        end
        n_checks++;
        if (rcPeriod !== exp_period) begin
            n_fail++;
            $display("FAIL rstmid_period got %0d want %0d", rcPeriod, exp_period);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_len = 0;
        rst_n    = 1'b0;
        PWM      = 1'b0;
        model_idle();
        @(negedge clk);
        test_reset();
        test_nominal();
        test_widths();
        test_glitch();
        test_back_to_back();
        test_failsafe_high();
        test_failsafe_low();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vin_rcservo.md
# vin_rcservo

RC-servo pulse decoder: measures the high time of an incoming 50–400 Hz RC PWM frame and reports it as a signed offset from the servo center. It is the receive counterpart of the joint RC-servo PWM generator and uses the same clock-unit center/range parameters. It sits between an FPGA input pin and the plugin's register interface. Typical sources are an RC receiver channel or another board's servo output. It adds input synchronisation, glitch filtering, and failsafe timeout.

## Interface
- servo_center, 72000, nominal pulse width in clk cycles (1.5 ms at 48 MHz)
- servo_minmax, 72000, maximum allowed deviation from center in clk cycles; output is clamped to ±servo_minmax
- servo_timeout, 960000, cycles without a rising edge (or stuck high) before failsafe; must be > servo_center + servo_minmax
- filter_len, 3, consecutive equal samples required to accept a new input level (1..15)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- PWM  input  1  asynchronous RC pulse input
- rcValue  output  signed 32  (width − servo_center), clamped
- rcPeriod  output  32  cycles between the last two accepted rising edges
- rcValid  output  1  high while frames arrive within timeout

## Operation
- Input path:
  - 2-FF synchroniser, then a filter counter.
  - The filtered level pwm_f changes only after filter_len consecutive synchronised samples differ from the current pwm_f.
  - pwm_f resets to 0.
- Edge detection on pwm_f (registered previous value):
  - rise = pwm_f & ~prev
  - fall = ~pwm_f & prev
- widthCnt and periodCnt are 32-bit counters.
  - Both saturate at servo_timeout and never wrap.
- States:
  - IDLE:
    - Entered after reset or failsafe.
    - Waits for rise; a pulse already high at reset is ignored until a full low→high transition.
    - On rise: go to HIGH, widthCnt←1, periodCnt←1.
  - HIGH:
    - widthCnt and periodCnt increment each cycle.
    - On fall: go to LOW and update rcValue.
    - If widthCnt reaches servo_timeout (input stuck high): failsafe.
  - LOW:
    - periodCnt increments.
    - On rise: rcPeriod←periodCnt, then widthCnt←1, periodCnt←1, go to HIGH.
    - If periodCnt reaches servo_timeout: failsafe.
- rcValue update on fall:
  - d = widthCnt − servo_center, computed as signed 33-bit.
  - Clamp to [−servo_minmax, +servo_minmax].
  - rcValid←1.
- Failsafe:
  - rcValue←0, rcValid←0, rcPeriod←0, state←IDLE.
- rcPeriod is updated only on a rise in LOW, so the first frame after IDLE yields no period.
- Simultaneous events: a timeout and an edge in the same cycle resolve as timeout (failsafe wins).
- Reset mid-pulse:
  - All state clears.
  - The next measured pulse must begin with a fresh rising edge.

## Timing
- Reset values:
  - rcValue=0, rcValid=0, rcPeriod=0
  - state=IDLE
  - sync/filter registers 0, counters 0
- Latency from PWM pin transition to pwm_f: 2 + filter_len cycles.
  - Applies equally to rising and falling transitions, so measured width equals pin width exactly.
- rcValue and rcValid update 1 cycle after the fall cycle.
- rcPeriod updates 1 cycle after the rise cycle.
- Failsafe outputs update 1 cycle after the counter reaches servo_timeout.
- Outputs hold between updates; there is no handshake.
  - Consumers sample rcValue at any time.
  - rcValid qualifies the data.
- Pulses shorter than filter_len cycles are rejected entirely and produce no output change.

## Test plan
- Reset, then a 72000-cycle high pulse, then a 408000-cycle low, repeated 3×:
  - rcValue=0 and rcValid=1 after the first fall.
  - rcPeriod=480000 after the second rise.
- Pulse widths of 36000 and 120000:
  - rcValue=−36000, then +48000.
- Clamp check with servo_minmax=24000:
  - Width 200000 gives rcValue=+24000.
  - Width 10 (above filter) gives −24000.
- Glitches: 2-cycle high spikes during LOW and 2-cycle low dropouts during HIGH (filter_len=3):
  - No change to rcValue or rcPeriod; width is measured as if the glitches were absent.
- Failsafe, low case: after a valid frame, hold PWM low.
  - rcValid→0, rcValue→0, rcPeriod→0 exactly 960000+1 cycles after the last accepted rise.
- Failsafe, high case: hold PWM high for the same duration.
  - Same result as the low case.
- Reset mid-pulse:
  - Assert rst_n=0 for 1 cycle while PWM is high, then release.
  - The remainder of that pulse is ignored; the next full pulse is measured correctly.
